// File: rtl/axi_arb_pkg.sv
// Shared types for the AXI write-channel arbiter: FSM states, BRESP codes
// and the one-hot to index helper.
package axi_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      RESP = 2'd3
   } arb_state_e;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   // Sized for the largest supported master count; callers zero-extend.
   function automatic logic [2:0] onehot2idx(input logic [7:0] oh);
      logic [2:0] idx;
      idx = '0;
      for (int i = 0; i < 8; i++) begin
         if (oh[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first requester after the last winner,
// wrapping around, wins.
module rr_arbiter #(
   parameter int NUM_M = 2,
   parameter int IDX_W = 1
) (
   input  logic [NUM_M-1:0] req,
   input  logic [IDX_W-1:0] last,
   output logic [NUM_M-1:0] winner
);

   logic [IDX_W-1:0] idx;
   logic             found;

   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      for (int k = 1; k <= NUM_M; k++) begin
         idx = IDX_W'((int'(last) + k) % NUM_M);
         if (!found && req[idx]) begin
            winner[idx] = 1'b1;
            found       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Shares one AXI4 slave write port between NUM_M masters, one whole transaction
// at a time. Define AXI_WR_ARB_BEAT_CHECK_EN to generate s_wlast from AWLEN.
module axi_wr_arbiter
   import axi_arb_pkg::*;
#(
   parameter int NUM_M      = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                           ACLK,
   input  logic                           ARESETn,
   // master side
   input  logic [NUM_M*ID_WIDTH-1:0]      m_awid,
   input  logic [NUM_M*ADDR_WIDTH-1:0]    m_awaddr,
   input  logic [NUM_M*LEN_WIDTH-1:0]     m_awlen,
   input  logic [NUM_M*3-1:0]             m_awsize,
   input  logic [NUM_M*2-1:0]             m_awburst,
   input  logic [NUM_M-1:0]               m_awvalid,
   output logic [NUM_M-1:0]               m_awready,
   input  logic [NUM_M*DATA_WIDTH-1:0]    m_wdata,
   input  logic [NUM_M*DATA_WIDTH/8-1:0]  m_wstrb,
   input  logic [NUM_M-1:0]               m_wlast,
   input  logic [NUM_M-1:0]               m_wvalid,
   output logic [NUM_M-1:0]               m_wready,
   output logic [NUM_M*ID_WIDTH-1:0]      m_bid,
   output logic [NUM_M*2-1:0]             m_bresp,
   output logic [NUM_M-1:0]               m_bvalid,
   input  logic [NUM_M-1:0]               m_bready,
   // slave side
   output logic [ID_WIDTH-1:0]            s_awid,
   output logic [ADDR_WIDTH-1:0]          s_awaddr,
   output logic [LEN_WIDTH-1:0]           s_awlen,
   output logic [2:0]                     s_awsize,
   output logic [1:0]                     s_awburst,
   output logic                           s_awvalid,
   input  logic                           s_awready,
   output logic [DATA_WIDTH-1:0]          s_wdata,
   output logic [DATA_WIDTH/8-1:0]        s_wstrb,
   output logic                           s_wlast,
   output logic                           s_wvalid,
   input  logic                           s_wready,
   input  logic [ID_WIDTH-1:0]            s_bid,
   input  logic [1:0]                     s_bresp,
   input  logic                           s_bvalid,
   output logic                           s_bready,
   // status
   output logic [NUM_M-1:0]               grant,
   output logic                           err_wlast,
   output logic [1:0]                     dbg_state
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int IDX_W  = (NUM_M > 1) ? $clog2(NUM_M) : 1;

   arb_state_e        state;
   logic [IDX_W-1:0]  last_idx;
   logic [IDX_W-1:0]  gidx;
   logic [NUM_M-1:0]  winner;
   logic              aw_hs, w_hs, b_hs;

   logic [ID_WIDTH-1:0]   awid_a   [NUM_M];
   logic [ADDR_WIDTH-1:0] awaddr_a [NUM_M];
   logic [LEN_WIDTH-1:0]  awlen_a  [NUM_M];
   logic [2:0]            awsize_a [NUM_M];
   logic [1:0]            awburst_a[NUM_M];
   logic [DATA_WIDTH-1:0] wdata_a  [NUM_M];
   logic [STRB_W-1:0]     wstrb_a  [NUM_M];

   for (genvar i = 0; i < NUM_M; i++) begin : g_unpack
      assign awid_a[i]    = m_awid[i*ID_WIDTH +: ID_WIDTH];
      assign awaddr_a[i]  = m_awaddr[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign awlen_a[i]   = m_awlen[i*LEN_WIDTH +: LEN_WIDTH];
      assign awsize_a[i]  = m_awsize[i*3 +: 3];
      assign awburst_a[i] = m_awburst[i*2 +: 2];
      assign wdata_a[i]   = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      assign wstrb_a[i]   = m_wstrb[i*STRB_W +: STRB_W];
   end

   rr_arbiter #(.NUM_M(NUM_M), .IDX_W(IDX_W)) u_rr (
      .req    (m_awvalid),
      .last   (last_idx),
      .winner (winner)
   );

   assign gidx      = IDX_W'(onehot2idx(8'(grant)));
   assign dbg_state = state;

   // All channels are AXI valid/ready: a beat transfers on the ACLK edge where
   // both are high, and only the granted master is ever connected to the slave.
   assign s_awid    = awid_a[gidx];
   assign s_awaddr  = awaddr_a[gidx];
   assign s_awlen   = awlen_a[gidx];
   assign s_awsize  = awsize_a[gidx];
   assign s_awburst = awburst_a[gidx];
   assign s_awvalid = (state == ADDR) && m_awvalid[gidx];
   assign m_awready = (state == ADDR) ? (grant & {NUM_M{s_awready}}) : '0;

   assign s_wdata   = wdata_a[gidx];
   assign s_wstrb   = wstrb_a[gidx];
   assign s_wvalid  = (state == DATA) && m_wvalid[gidx];
   assign m_wready  = (state == DATA) ? (grant & {NUM_M{s_wready}}) : '0;

   assign m_bid     = {NUM_M{s_bid}};
   assign m_bresp   = {NUM_M{s_bresp}};
   assign m_bvalid  = (state == RESP) ? (grant & {NUM_M{s_bvalid}}) : '0;
   assign s_bready  = (state == RESP) && m_bready[gidx];

   assign aw_hs = s_awvalid && s_awready;
   assign w_hs  = s_wvalid && s_wready;
   assign b_hs  = s_bvalid && s_bready;

`ifdef AXI_WR_ARB_BEAT_CHECK_EN
   // Holds beats still to come, so AWLEN=255 loads 256 without wrapping.
   logic [LEN_WIDTH:0] beat_cnt;
   logic               cnt_last;

   assign cnt_last = (beat_cnt == (LEN_WIDTH+1)'(1));
   assign s_wlast  = (state == DATA) && cnt_last;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         beat_cnt  <= '0;
         err_wlast <= 1'b0;
      end else begin
         err_wlast <= w_hs && (m_wlast[gidx] != cnt_last);
         if (aw_hs)
            beat_cnt <= {1'b0, s_awlen} + (LEN_WIDTH+1)'(1);
         else if (w_hs)
            beat_cnt <= beat_cnt - (LEN_WIDTH+1)'(1);
      end
   end
`else
   assign s_wlast   = m_wlast[gidx];
   assign err_wlast = 1'b0;
`endif

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state    <= IDLE;
         grant    <= '0;
         last_idx <= IDX_W'(NUM_M - 1);
      end else begin
         case (state)
            IDLE: if (|m_awvalid) begin
               grant <= winner;
               state <= ADDR;
            end
            ADDR: if (aw_hs) state <= DATA;
            DATA: if (w_hs && s_wlast) state <= RESP;
            RESP: if (b_hs) begin
               last_idx <= gidx;
               grant    <= '0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/axi_wr_arbiter.md
# axi_wr_arbiter

Round-robin arbiter that shares one AXI4 slave write port (AW, W, B channels) between NUM_M AXI4 masters. It sits between the master-side agents/interconnect stubs and a single slave interface. It grants one master at a time for a whole write transaction: address, all data beats, then the response. Read channels are out of scope and are connected around this block.

## Interface

Parameters:
- NUM_M, 2, number of masters (2..8)
- ADDR_WIDTH, 32, AWADDR width
- DATA_WIDTH, 32, WDATA width; WSTRB is DATA_WIDTH/8
- ID_WIDTH, 4, AWID/BID width
- LEN_WIDTH, 8, AWLEN width

Ports:
- Clocking: single clock; reset is asynchronous and active-low.
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- m_awid/awaddr/awlen/awsize/awburst  in  NUM_M×field  per-master AW payload, packed with master i at slice i
- m_awvalid  in  NUM_M  per-master AWVALID
- m_awready  out  NUM_M  per-master AWREADY
- m_wdata/wstrb  in  NUM_M×field  per-master W payload
- m_wlast, m_wvalid  in  NUM_M  per-master WLAST/WVALID
- m_wready  out  NUM_M
- m_bid, m_bresp  out  NUM_M×field  broadcast B payload
- m_bvalid  out  NUM_M; m_bready  in  NUM_M
- s_aw*, s_w*, s_b*  single slave-side copies of the same signals, opposite directions
- grant  out  NUM_M  one-hot current owner, 0 when idle
- err_wlast  out  1  one-cycle pulse on WLAST/beat-count mismatch

## Operation

- FSM states (in axi_arb_pkg): IDLE, ADDR, DATA, RESP.
- IDLE:
  - If any m_awvalid is set, pick a winner round-robin starting at the index after the last winner.
  - Register the winner into grant and go to ADDR.
  - With no requests, stay in IDLE.
- ADDR:
  - The granted master's AW payload and valid go combinationally to s_aw*.
  - s_awready goes back to that master's m_awready.
  - On the s_awvalid&&s_awready handshake, latch AWLEN into the beat counter and go to DATA.
- DATA:
  - The granted master's W channel is forwarded.
  - On a W handshake with s_wlast=1, go to RESP.
- RESP:
  - s_bvalid/bid/bresp go to the granted master only.
  - On the B handshake, update the round-robin pointer to the granted index, clear grant, and go to IDLE.
- Ungranted masters always see awready=0, wready=0, bvalid=0.
- W ahead of AW: a master's W data is not accepted before its AW handshake. Masters hold W until then.
- Simultaneous requests: only the round-robin winner is granted. The others keep AWVALID asserted and wait.
- Beat counter width is LEN_WIDTH+1, so AWLEN=255 gives 256 beats without wrap.
- Reset mid-transaction: the transaction is abandoned immediately and the next grant starts from master 0.

## Timing

- Reset values:
  - state=IDLE, grant=0, pointer set so master 0 has top priority, beat counter=0, err_wlast=0.
  - All m_awready/m_wready/m_bvalid = 0.
  - s_awvalid=s_wvalid=s_bready=0.
- Arbitration latency: request at edge N → grant registered at N+1 → s_awvalid high in cycle N+1. Minimum one idle cycle between transactions.
- Data, ready and valid paths are combinational through the mux; no added beat latency.
- A single-beat write completes in at least 4 cycles: grant, AW, W, B.
- Back-to-back transactions from different masters alternate strictly when all request continuously.

## Configuration

- AXI_WR_ARB_BEAT_CHECK_EN defined:
  - s_wlast is generated from the beat counter and asserted on the final beat.
  - If the master's WLAST disagrees with the counter on any beat, err_wlast pulses for one cycle.
  - The FSM follows the counter.
- Undefined:
  - s_wlast passes the granted master's WLAST through.
  - No beat counter is built; err_wlast is tied 0.

## Structure

- axi_arb_pkg holds:
  - arb_state_e enum.
  - BRESP constants OKAY=2'b00, SLVERR=2'b10.
  - Helper function onehot2idx.
- One sub-module, rr_arbiter:
  - Inputs: NUM_M request vector, last-winner pointer.
  - Output: one-hot winner.
  - Purely combinational.
- Top level holds the FSM, muxes, and the optional beat counter.

## Test plan

- Single master 0 writes AWADDR=0x1000, AWLEN=0, data 0xDEADBEEF → slave sees one beat with WLAST=1; master 0 gets BRESP=OKAY; grant returns to 0.
- Masters 0 and 1 both request continuously for 4 transactions → grant order 0,1,0,1; no overlap of s_awvalid between transactions.
- Master 1 burst AWLEN=255 → 256 W beats forwarded; master 0's AWVALID held throughout with m_awready[0]=0; master 0 granted after B.
- Master drives WLAST on beat 2 of an AWLEN=3 burst:
  - With the macro: err_wlast=1 for one cycle and s_wlast only on beat 4.
  - Without the macro: s_wlast on beat 2.
- ARESETn asserted during DATA beat 2 → all outputs at reset values asynchronously; after release, master 0 request is granted first.
- Slave returns BRESP=SLVERR with BID=0x5 → delivered only to the granted master; the other master's m_bvalid stays 0.
